// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM encoding, flag bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    // Opcode encoding (4-bit, unchanged from the legacy ALU for the logic/arith ops)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b1000;
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_EOR  = 4'b1100;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add serial multiplier: one multiplier bit per cycle, low N bits of the product.
// Latency: done_o pulses N cycles after start_i; prod_o is valid in that same cycle.
// Backpressure: none; the parent must hold off new starts until done_o.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N   = 64,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] prod_o
);

    logic [N-1:0]   a_q, b_q, acc_q;
    logic [N-1:0]   acc_d;
    logic [SHW-1:0] cnt_q;
    logic           active_q;

    // Partial product for the current multiplier bit; on the last step this is the final product
    always_comb begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
    end

    assign done_o = active_q && (cnt_q == SHW'(N-1));
    assign prod_o = acc_d;

    // Operand latch on start, then shift multiplicand left / multiplier right each cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SHW'(N-1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked execute-stage ALU with NZCV flags; MUL built only when ALU_SEQ_MUL_EN is defined.
// Latency: 1 cycle for logic/arith/shift/illegal ops, N+1 cycles for MUL; 1 op/cycle with out_ready held high.
// Backpressure: result held stable while out_ready=0; in_ready drops during BUSY and in DONE without out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 64,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [3:0]   opt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ALUout,
    output logic         zero,
    output logic [3:0]   flags,
    output logic         err
);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   res_q;
    logic [3:0]     flags_q;
    logic           err_q;

    logic           accept;
    logic           is_mul;
    logic           mul_done;
    logic [N-1:0]   mul_prod;

    logic [N:0]     sum_w, diff_w;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   alu_res;
    logic           alu_c, alu_v, alu_err;
    logic [3:0]     alu_flags;
    logic [3:0]     mul_flags;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    assign ALUout = res_q;
    assign flags  = flags_q;
    assign err    = err_q;
    assign zero   = out_valid && flags_q[FLAG_Z];

    // Extra top bit carries the adder carry-out / subtractor borrow
    assign sum_w  = {1'b0, in1} + {1'b0, in2};
    assign diff_w = {1'b0, in1} - {1'b0, in2};
    assign shamt  = in2[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
    assign is_mul = (opt == OP_MUL);

    alu_mul_iter #(
        .N   (N),
        .SHW (SHW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept && is_mul),
        .a_i     (in1),
        .b_i     (in2),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    // No multiplier: 1011 falls through to the illegal-opcode path
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // Single-cycle datapath: result, carry/overflow and illegal-opcode detection
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (opt)
            OP_AND:  alu_res = in1 & in2;
            OP_ORR:  alu_res = in1 | in2;
            OP_EOR:  alu_res = in1 ^ in2;
            OP_PASS: alu_res = in2;
            OP_ADD: begin
                alu_res = sum_w[N-1:0];
                alu_c   = sum_w[N];
                alu_v   = (in1[N-1] == in2[N-1]) && (sum_w[N-1] != in1[N-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[N-1:0];
                alu_c   = ~diff_w[N];
                alu_v   = (in1[N-1] != in2[N-1]) && (diff_w[N-1] != in1[N-1]);
            end
            OP_LSL:  alu_res = in1 << shamt;
            OP_LSR:  alu_res = in1 >> shamt;
            OP_ASR:  alu_res = $unsigned($signed(in1) >>> shamt);
            default: alu_err = 1'b1;
        endcase
        alu_flags         = 4'b0000;
        alu_flags[FLAG_N] = alu_res[N-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // Multiply results never set carry or overflow
    always_comb begin
        mul_flags         = 4'b0000;
        mul_flags[FLAG_N] = mul_prod[N-1];
        mul_flags[FLAG_Z] = (mul_prod == '0);
    end

    // Next state: an accept (from IDLE or DONE) overrides the drain/hold behaviour
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: ;
            ST_BUSY: if (mul_done)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = is_mul ? ST_BUSY : ST_DONE;
        end
    end

    // State and held result; outputs only move on an accept, multiply completion or reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_mul) begin
                res_q   <= alu_res;
                flags_q <= alu_flags;
                err_q   <= alu_err;
            end else if (mul_done) begin
                res_q   <= mul_prod;
                flags_q <= mul_flags;
                err_q   <= 1'b0;
            end
        end
    end

endmodule
